// File: rtl/banked_memory_pkg.sv
// Line geometry, bank/line field extraction and the return-FIFO entry type
// shared by banked_memory and its bank sub-module.
package banked_memory_pkg;

  localparam int unsigned BEATS      = 4;
  localparam int unsigned LINE_SHIFT = 5;
  localparam int unsigned ENT_ADDR_W = 64;
  localparam int unsigned ENT_LINE_W = 32;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_BEAT1 = 2'd1,
    W_BEAT2 = 2'd2,
    W_BEAT3 = 2'd3
  } wr_state_t;

  // Fields sized for the widest supported configuration; the top narrows them.
  typedef struct packed {
    logic [ENT_ADDR_W-1:0] addr;
    logic [ENT_LINE_W-1:0] line;
  } ret_entry_t;

  // Line-granular field of a byte address, modulo a power-of-two count.
  function automatic logic [31:0] line_field(input logic [63:0] a, input int unsigned n);
    return 32'((a >> LINE_SHIFT) & (64'(n) - 64'd1));
  endfunction

  function automatic logic [31:0] bank_sel(input logic [63:0] a, input int unsigned num_banks);
    return line_field(a, num_banks);
  endfunction

endpackage

// File: rtl/banked_memory_bank.sv
// One bank's busy timer: a down-counter loaded on accept, remembering whether
// the operation was a read so completion can be reported with its address.
module banked_memory_bank #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LAT    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_is_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr
);

  localparam int unsigned CNT_W = $clog2(LAT + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_read;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_read <= 1'b0;
      r_addr    <= '0;
    end else if (i_load) begin
      r_cnt     <= CNT_W'(LAT);
      r_is_read <= i_is_read;
      r_addr    <= i_addr;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = r_is_read & (r_cnt == CNT_W'(1));
  assign o_addr = r_addr;

endmodule

// File: rtl/banked_memory.sv
// Banked line memory: 4-beat write bursts, single-cycle read requests, and
// in-order 4-beat read returns through a small completion FIFO.
//   state      | meaning
//   W_IDLE     | no write burst in flight; a write here is beat 0
//   W_BEAT1..3 | expecting beat 1..3 of the current write burst
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned MEM_LINES = 1024,
  parameter int unsigned BANK_LAT  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              error
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned LINE_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_BANKS + 1);

  wr_state_t         r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wbuf  [3];
  logic [DATA_W-1:0] r_mem   [MEM_LINES][BEATS];
  ret_entry_t        r_fifo  [NUM_BANKS];
  logic [DATA_W-1:0] r_fdata [NUM_BANKS][BEATS];
  logic [BANK_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_fcount, r_outst;
  logic [1:0]        r_rbeat;
  logic              r_error;

  logic [BANK_W-1:0]    w_bank, w_wbank;
  logic [LINE_W-1:0]    w_wline, w_cline;
  logic                 w_mid, w_aligned, w_sel_busy, w_credit_full;
  logic                 w_rd_acc, w_wr_start, w_beat_ok;
  logic                 w_capture, w_commit, w_burst_err;
  logic [1:0]           w_cap_idx;
  logic [NUM_BANKS-1:0] w_busy, w_done, w_load;
  logic [ADDR_W-1:0]    w_bank_addr [NUM_BANKS];
  logic                 w_push, w_pop, w_empty;
  logic [ADDR_W-1:0]    w_cmpl_addr;

  assign w_bank  = BANK_W'(bank_sel(64'(addr), NUM_BANKS));
  assign w_wbank = BANK_W'(bank_sel(64'(r_waddr), NUM_BANKS));
  assign w_wline = LINE_W'(line_field(64'(r_waddr), MEM_LINES));
  assign w_cline = LINE_W'(line_field(64'(w_cmpl_addr), MEM_LINES));

  assign w_mid         = (r_wstate != W_IDLE);
  assign w_aligned     = (addr[LINE_SHIFT-1:0] == '0);
  assign w_sel_busy    = w_busy[w_bank];
  assign w_credit_full = (r_outst == CNT_W'(NUM_BANKS));

  // A read also needs a free return slot, so a completing bank never finds the FIFO full.
  assign ready      = w_mid | (~w_sel_busy & ~(read & w_credit_full));
  assign w_rd_acc   = read & ~write & w_aligned & ~w_mid & ready;
  assign w_wr_start = write & ~read & w_aligned & ~w_mid & ready;
  assign w_beat_ok  = write & ~read & (addr == r_waddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wstate <= W_IDLE;
    else      r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_start) w_wstate_nxt = W_BEAT1;
      W_BEAT1: w_wstate_nxt = w_beat_ok ? W_BEAT2 : W_IDLE;
      W_BEAT2: w_wstate_nxt = w_beat_ok ? W_BEAT3 : W_IDLE;
      W_BEAT3: w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // A broken burst is dropped: nothing is committed and the bank stays idle.
  always_comb begin
    w_capture   = 1'b0;
    w_cap_idx   = 2'd0;
    w_commit    = 1'b0;
    w_burst_err = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_capture = w_wr_start;
        w_cap_idx = 2'd0;
      end
      W_BEAT1: begin
        w_capture   = w_beat_ok;
        w_cap_idx   = 2'd1;
        w_burst_err = ~w_beat_ok;
      end
      W_BEAT2: begin
        w_capture   = w_beat_ok;
        w_cap_idx   = 2'd2;
        w_burst_err = ~w_beat_ok;
      end
      W_BEAT3: begin
        w_commit    = w_beat_ok;
        w_burst_err = ~w_beat_ok;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_load[g] = (w_rd_acc && (w_bank == BANK_W'(g))) ||
                       (w_commit && (w_wbank == BANK_W'(g)));

    banked_memory_bank #(
      .ADDR_W (ADDR_W),
      .LAT    (BANK_LAT)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst),
      .i_load    (w_load[g]),
      .i_is_read (w_rd_acc),
      .i_addr    (addr),
      .o_busy    (w_busy[g]),
      .o_done    (w_done[g]),
      .o_addr    (w_bank_addr[g])
    );
  end

  // Fixed latency and one accept per cycle mean at most one bank completes per cycle.
  always_comb begin
    w_push      = 1'b0;
    w_cmpl_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_done[b]) begin
        w_push      = 1'b1;
        w_cmpl_addr = w_bank_addr[b];
      end
    end
  end

  assign w_empty = (r_fcount == '0);
  assign w_pop   = ~w_empty & (r_rbeat == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_waddr  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcount <= '0;
      r_outst  <= '0;
      r_rbeat  <= 2'd0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_start) r_waddr <= addr;
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_wr_ptr + BANK_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rd_ptr + BANK_W'(1);
      r_fcount <= r_fcount + CNT_W'(w_push) - CNT_W'(w_pop);
      r_outst  <= r_outst + CNT_W'(w_rd_acc) - CNT_W'(w_pop);
      if (w_pop)         r_rbeat <= 2'd0;
      else if (!w_empty) r_rbeat <= r_rbeat + 2'd1;
      r_error <= r_error | (read & write) | ((read | write) & ~w_aligned) | w_burst_err;
    end
  end

  // Line data is captured at completion so a later write to the line cannot leak into a queued return.
  always_ff @(posedge clk) begin
    if (w_capture) r_wbuf[w_cap_idx] <= wdata;
    if (w_commit) begin
      r_mem[w_wline][0] <= r_wbuf[0];
      r_mem[w_wline][1] <= r_wbuf[1];
      r_mem[w_wline][2] <= r_wbuf[2];
      r_mem[w_wline][3] <= wdata;
    end
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{addr: ENT_ADDR_W'(w_cmpl_addr), line: ENT_LINE_W'(w_cline)};
      for (int i = 0; i < BEATS; i++) r_fdata[r_wr_ptr][i] <= r_mem[w_cline][i];
    end
  end

  assign rvalid = ~w_empty;
  assign raddr  = w_empty ? '0 : ADDR_W'(r_fifo[r_rd_ptr].addr);
  assign rdata  = w_empty ? '0 : r_fdata[r_rd_ptr][r_rbeat];
  assign error  = r_error;

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench for banked_memory: write/read bursts, bank conflicts,
// back-to-back returns, address wrap, reset abandonment and error flagging.
module tb_banked_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic        ready;
  logic [31:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banked_memory dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .read   (read),
    .write  (write),
    .wdata  (wdata),
    .ready  (ready),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .error  (error)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3);
    int n;
    n = 0;
    read = 1'b0; write = 1'b1; addr = a; wdata = d0;
    #1;
    while (!ready && n < 50) begin step(); #1; n++; end
    check_val({tag, "_rdy"}, ready, 1);
    step(); wdata = d1;
    step(); wdata = d2;
    step(); wdata = d3;
    step();
    idle_in();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output int waits);
    waits = 0;
    write = 1'b0; read = 1'b1; addr = a;
    #1;
    while (!ready && waits < 50) begin step(); #1; waits++; end
    check_val({tag, "_rdy"}, ready, 1);
    step();
    idle_in();
  endtask

  task automatic wait_rvalid(input string tag, output int n);
    n = 0;
    while (!rvalid && n < 60) begin step(); n++; end
    check_val({tag, "_rv"}, rvalid, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (rvalid && n < 60) begin step(); n++; end
    check_val({tag, "_drain"}, rvalid, 0);
  endtask

  task automatic expect_burst(input string tag, input logic [31:0] a,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_v%0d", tag, i), rvalid, 1);
      check_val($sformatf("%s_a%0d", tag, i), raddr, a);
      check_val($sformatf("%s_d%0d", tag, i), rdata, d[i]);
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;

    rst = 1'b0;
    idle_in();
    repeat (3) step();
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_error", error, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_raddr", raddr, 0);
    check_val("rst_ready", ready, 1);
    rst = 1'b1;
    step();

    // Known contents for lines 0x000 (bank 0) and 0x020 (bank 1).
    do_write("wr000", 32'h000, 64'hA0, 64'hA1, 64'hA2, 64'hA3);

    // Write then read 0x100: 6 blocked cycles, first beat 7 cycles after accept.
    do_write("wr100", 32'h100, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    do_read("rd100", 32'h100, w);
    check_val("rd100_blocked", w, 6);
    wait_rvalid("rd100", n);
    check_val("rd100_latency", n + 1, 7);
    expect_burst("rd100", 32'h100, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
    check_val("rd100_end_rv", rvalid, 0);
    check_val("rd100_end_rd", rdata, 0);
    check_val("rd100_end_ra", raddr, 0);

    do_write("wr020", 32'h020, 64'hB0, 64'hB1, 64'hB2, 64'hB3);
    repeat (10) step();

    // Back-to-back reads on banks 0 and 1: eight contiguous beats, 0x000 first.
    do_read("b2b0", 32'h000, w);
    check_val("b2b0_wait", w, 0);
    do_read("b2b1", 32'h020, w);
    check_val("b2b1_wait", w, 0);
    wait_rvalid("b2b", n);
    check_val("b2b_first", n, 5);
    expect_burst("b2b_x000", 32'h000, 64'hA0, 64'hA1, 64'hA2, 64'hA3);
    expect_burst("b2b_x020", 32'h020, 64'hB0, 64'hB1, 64'hB2, 64'hB3);
    check_val("b2b_end_rv", rvalid, 0);

    // Same-bank conflict: 0x0C0 waits 6 cycles behind 0x040.
    do_read("cf040", 32'h040, w);
    check_val("cf040_wait", w, 0);
    do_read("cf0c0", 32'h0C0, w);
    check_val("cf0c0_wait", w, 6);
    check_val("cf040_rv", rvalid, 1);
    check_val("cf040_ra", raddr, 32'h040);
    wait_drain("cf040");
    wait_rvalid("cf0c0", n);
    check_val("cf0c0_ra", raddr, 32'h0C0);
    wait_drain("cf0c0");

    // 0x8000 wraps onto line 0.
    do_read("wrap", 32'h8000, w);
    wait_rvalid("wrap", n);
    expect_burst("wrap", 32'h8000, 64'hA0, 64'hA1, 64'hA2, 64'hA3);

    // Reset during beat 2 abandons the burst; old line contents survive.
    do_write("wr200", 32'h200, 64'hC0, 64'hC1, 64'hC2, 64'hC3);
    repeat (10) step();
    write = 1'b1; addr = 32'h200; wdata = 64'hD0;
    #1;
    check_val("abort_rdy", ready, 1);
    step(); wdata = 64'hD1;
    step(); wdata = 64'hD2;
    #1;
    rst = 1'b0;
    #1;
    check_val("abort_err", error, 0);
    check_val("abort_rv", rvalid, 0);
    idle_in();
    step();
    step();
    rst = 1'b1;
    step();
    do_read("rd200", 32'h200, w);
    check_val("rd200_wait", w, 0);
    wait_rvalid("rd200", n);
    expect_burst("rd200", 32'h200, 64'hC0, 64'hC1, 64'hC2, 64'hC3);
    check_val("rd200_err", error, 0);

    // read and write together: sticky error until reset.
    read = 1'b1; write = 1'b1; addr = 32'h000;
    #1;
    check_val("rw_pre", error, 0);
    step();
    idle_in();
    check_val("rw_set", error, 1);
    repeat (5) step();
    check_val("rw_sticky", error, 1);
    rst = 1'b0;
    #1;
    check_val("rw_cleared", error, 0);
    step();
    rst = 1'b1;
    step();

    // Misaligned read: flagged and never returned.
    read = 1'b1; addr = 32'h004;
    step();
    idle_in();
    check_val("mis_set", error, 1);
    repeat (10) step();
    check_val("mis_norv", rvalid, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_val("mis_cleared", error, 0);

    // Address change during beat 1.
    write = 1'b1; addr = 32'h300; wdata = 64'hE0;
    step();
    check_val("chg_beat0", error, 0);
    addr = 32'h320; wdata = 64'hE1;
    step();
    idle_in();
    check_val("chg_set", error, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
